mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single memory_bus instance (ROM, RAM, peripherals) between the CPU core and a secondary bus master (DMA/debug loader).
- Sequences each access as a fixed-length issue/wait/complete transaction on the bus.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Sits between the riscv core / DMA engine and memory_bus; runs on the divided CPU clock.

Parameters:
- LATENCY, 1, cycles from the bus_enable cycle to the cycle in which mem_read is sampled (1..4).
- CPU_PRIORITY, 0, 0 = round-robin between ports; 1 = CPU always wins when both ports request.

Ports:
- clk  input  1  CPU clock (divided clock).
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU transaction request, held until cpu_ready.
- cpu_write  input  1  1 = write, 0 = read.
- cpu_address  input  16  byte address.
- cpu_data_in  input  32  write data (pre-replicated by the requester).
- cpu_write_mask  input  4  per-byte mask, 0 = byte written (memory_bus convention).
- cpu_data_out  output  32  read data.
- cpu_ready  output  1  one-cycle completion pulse.
- dma_req, dma_write, dma_address, dma_data_in, dma_write_mask, dma_data_out, dma_ready  same widths and directions as the CPU port.
- mem_address  output  16  to memory_bus address.
- mem_write  output  32  to memory_bus data_in.
- mem_write_mask  output  4  to memory_bus write_mask.
- mem_read  input  32  from memory_bus data_out.
- mem_bus_enable  output  1  to memory_bus bus_enable.
- mem_write_enable  output  1  to memory_bus write_enable.
- busy  output  1  high in any state other than IDLE.
- grant  output  1  port owning the current/last transaction (0 = CPU, 1 = DMA).

Behaviour:
- Reset (async assert, any state):
  - State → IDLE.
  - All outputs to 0, including both data_out registers, mem_* and both ready outputs.
  - last_grant = 1, so the CPU wins the first tie.
  - A transaction in flight is abandoned with no ready pulse.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No requests → stay in IDLE.
  - Exactly one request → grant that port.
  - Both requesting, CPU_PRIORITY = 1 → grant the CPU.
  - Both requesting, CPU_PRIORITY = 0 → grant the port opposite last_grant.
  - On grant: latch the granted port's address, data_in, write_mask and write into the mem_* registers; set grant and last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - mem_bus_enable = 1; mem_write_enable = latched write.
  - Load wait counter with LATENCY-1; go to WAIT.
- WAIT:
  - mem_bus_enable = 0, mem_write_enable = 0.
  - mem_address, mem_write and mem_write_mask hold their values.
  - Counter decrements each cycle; at 0, go to DONE.
  - On the final WAIT cycle, a read samples mem_read into the granted port's data_out.
- DONE (1 cycle):
  - Granted port's ready = 1; the other port's ready stays 0.
  - data_out is valid this cycle and holds until that port's next read completes.
  - Writes do not alter data_out.
  - Next state IDLE.
- Timing: request high in IDLE at cycle 0 → bus_enable at cycle 1 → ready at cycle 2+LATENCY → next arbitration at cycle 3+LATENCY.
- Throughput: one transaction per 3+LATENCY cycles.
- Requester rules:
  - Fields must stay stable while req is high and ready has not yet pulsed.
  - The requester may update fields and keep req high in the ready cycle for a back-to-back access.
  - The arbiter samples the new request in the following IDLE cycle.
- Round-robin bound: a continuously requesting port waits at most one foreign transaction.
- req dropped mid-transaction: the bus transaction completes and ready still pulses; no cancellation.
- A request arriving during ISSUE, WAIT or DONE is not seen until IDLE.
- mem_bus_enable and mem_write_enable are never high in the same cycle as any ready pulse.
- Address and write mask pass through unmodified; alignment is the requester's job.

Test Plan:
- Single CPU read, LATENCY = 1, address 0x4000, mem_read model returns 0xDEADBEEF → bus_enable at cycle 1, cpu_ready at cycle 3, cpu_data_out = 0xDEADBEEF, dma_ready stays 0.
- CPU write to 0x8000, data 0x000000AA, mask 4'b1110 → mem_write_enable and mem_bus_enable high together for exactly 1 cycle, mem_write_mask = 4'b1110, cpu_data_out unchanged.
- Both ports request continuously, CPU_PRIORITY = 0 → grants alternate CPU, DMA, CPU, DMA; ready pulses spaced exactly 4 cycles apart.
- Same traffic with CPU_PRIORITY = 1 → all grants go to the CPU; dma_ready never pulses while cpu_req stays high.
- LATENCY = 3, DMA read → mem_read sampled at cycle 4, dma_ready at cycle 5; changing mem_read after cycle 4 does not alter dma_data_out.
- reset asserted low during WAIT → all outputs 0 immediately, no ready pulse; after release with cpu_req held, a fresh transaction starts from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side (CPU, DMA) and memory_bus-side signals of the two-port memory arbiter.
// The arbiter takes the slave view; the requesters and the memory model take the master view.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_write_mask;
  logic [31:0] cpu_data_out;
  logic        cpu_ready;

  logic        dma_req;
  logic        dma_write;
  logic [15:0] dma_address;
  logic [31:0] dma_data_in;
  logic [3:0]  dma_write_mask;
  logic [31:0] dma_data_out;
  logic        dma_ready;

  logic [15:0] mem_address;
  logic [31:0] mem_write;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read;
  logic        mem_bus_enable;
  logic        mem_write_enable;

  modport slave (
    input  cpu_req, cpu_write, cpu_address, cpu_data_in, cpu_write_mask,
    output cpu_data_out, cpu_ready,
    input  dma_req, dma_write, dma_address, dma_data_in, dma_write_mask,
    output dma_data_out, dma_ready,
    output mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable,
    input  mem_read
  );

  modport master (
    output cpu_req, cpu_write, cpu_address, cpu_data_in, cpu_write_mask,
    input  cpu_data_out, cpu_ready,
    output dma_req, dma_write, dma_address, dma_data_in, dma_write_mask,
    input  dma_data_out, dma_ready,
    input  mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable,
    output mem_read
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for memory_bus: one transaction per 3+LATENCY cycles, ready 2+LATENCY after request.
// Requesters hold req and fields until their one-cycle ready; requests are only sampled in IDLE.
module mem_arbiter #(
  parameter int LATENCY      = 1,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic        last_grant;
  logic        wr_lat;
  logic [15:0] addr_q;
  logic [31:0] wdat_q;
  logic [3:0]  mask_q;
  logic [31:0] cpu_dat_q, dma_dat_q;
  logic        any_req, pick_dma;
  logic        bus_en, wr_en, cpu_rdy, dma_rdy;

  // On a tie, round-robin hands the bus to the port that did not own it last.
  assign any_req  = bus.cpu_req | bus.dma_req;
  assign pick_dma = bus.dma_req & (~bus.cpu_req | (~CPU_PRIORITY & ~last_grant));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_en    = 1'b0;
    wr_en     = 1'b0;
    cpu_rdy   = 1'b0;
    dma_rdy   = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        bus_en    = 1'b1;
        wr_en     = wr_lat;
        state_nxt = WAIT;
      end
      WAIT:  if (cnt == 2'd0) state_nxt = DONE;
      DONE: begin
        cpu_rdy   = ~grant;
        dma_rdy   = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 2'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wr_lat     <= 1'b0;
      addr_q     <= 16'd0;
      wdat_q     <= 32'd0;
      mask_q     <= 4'd0;
      cpu_dat_q  <= 32'd0;
      dma_dat_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant      <= pick_dma;
          last_grant <= pick_dma;
          wr_lat     <= pick_dma ? bus.dma_write      : bus.cpu_write;
          addr_q     <= pick_dma ? bus.dma_address    : bus.cpu_address;
          wdat_q     <= pick_dma ? bus.dma_data_in    : bus.cpu_data_in;
          mask_q     <= pick_dma ? bus.dma_write_mask : bus.cpu_write_mask;
        end
        ISSUE: cnt <= LAT_M1;
        WAIT: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else if (!wr_lat) begin
            if (grant) dma_dat_q <= bus.mem_read;
            else       cpu_dat_q <= bus.mem_read;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_address      = addr_q;
  assign bus.mem_write        = wdat_q;
  assign bus.mem_write_mask   = mask_q;
  assign bus.mem_bus_enable   = bus_en;
  assign bus.mem_write_enable = wr_en;
  assign bus.cpu_data_out     = cpu_dat_q;
  assign bus.dma_data_out     = dma_dat_q;
  assign bus.cpu_ready        = cpu_rdy;
  assign bus.dma_ready        = dma_rdy;
  assign busy                 = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover round-robin/LATENCY=1,
// CPU priority/LATENCY=1 and round-robin/LATENCY=3; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if ia ();
  mem_arbiter_if ib ();
  mem_arbiter_if ic ();
  logic busy_a, grant_a, busy_b, grant_b, busy_c, grant_c;

  mem_arbiter #(.LATENCY(1), .CPU_PRIORITY(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ia), .busy(busy_a), .grant(grant_a));
  mem_arbiter #(.LATENCY(1), .CPU_PRIORITY(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ib), .busy(busy_b), .grant(grant_b));
  mem_arbiter #(.LATENCY(3), .CPU_PRIORITY(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(ic), .busy(busy_c), .grant(grant_c));

  task automatic clear_inputs();
    ia.cpu_req = 0; ia.cpu_write = 0; ia.cpu_address = 0; ia.cpu_data_in = 0; ia.cpu_write_mask = 0;
    ia.dma_req = 0; ia.dma_write = 0; ia.dma_address = 0; ia.dma_data_in = 0; ia.dma_write_mask = 0; ia.mem_read = 0;
    ib.cpu_req = 0; ib.cpu_write = 0; ib.cpu_address = 0; ib.cpu_data_in = 0; ib.cpu_write_mask = 0;
    ib.dma_req = 0; ib.dma_write = 0; ib.dma_address = 0; ib.dma_data_in = 0; ib.dma_write_mask = 0; ib.mem_read = 0;
    ic.cpu_req = 0; ic.cpu_write = 0; ic.cpu_address = 0; ic.cpu_data_in = 0; ic.cpu_write_mask = 0;
    ic.dma_req = 0; ic.dma_write = 0; ic.dma_address = 0; ic.dma_data_in = 0; ic.dma_write_mask = 0; ic.mem_read = 0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    outs = {ia.mem_address, ia.mem_write_mask, ia.mem_bus_enable, ia.mem_write_enable,
            ia.cpu_ready, ia.dma_ready, busy_a, grant_a, 6'd0};
    checks++;
    if (outs !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", outs); end
    checks++;
    if ({ia.cpu_data_out, ia.dma_data_out, ia.mem_write} !== 96'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", ia.cpu_data_out, ia.dma_data_out, ia.mem_write);
    end
    reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    int rdy_cyc = 0;
    int dma_seen = 0;
    @(negedge clk);
    ia.cpu_req = 1; ia.cpu_write = 0; ia.cpu_address = 16'h4000; ia.mem_read = 32'hDEADBEEF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({ia.mem_bus_enable, ia.mem_write_enable, ia.mem_address, busy_a, grant_a} !== {2'b10, 16'h4000, 2'b10}) begin
          errors++; $display("FAIL rd_issue got be=%b we=%b a=%h busy=%b g=%b want 1 0 4000 1 0",
                              ia.mem_bus_enable, ia.mem_write_enable, ia.mem_address, busy_a, grant_a);
        end
      end
      if (ia.cpu_ready && rdy_cyc == 0) begin rdy_cyc = c; ia.cpu_req = 0; end
      if (ia.dma_ready) dma_seen++;
      if (c == 3) begin
        checks++;
        if (ia.cpu_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", ia.cpu_data_out); end
      end
    end
    checks++;
    if (rdy_cyc !== 3) begin errors++; $display("FAIL rd_ready_cycle got %0d want 3", rdy_cyc); end
    checks++;
    if (dma_seen !== 0) begin errors++; $display("FAIL rd_dma_ready got %0d pulses want 0", dma_seen); end
  endtask

  task automatic test_cpu_write();
    int both = 0;
    int overlap = 0;
    int rdy_cyc = 0;
    ia.cpu_req = 1; ia.cpu_write = 1; ia.cpu_address = 16'h8000; ia.cpu_data_in = 32'h000000AA;
    ia.cpu_write_mask = 4'b1110; ia.mem_read = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (ia.mem_bus_enable && ia.mem_write_enable) both++;
      if ((ia.mem_bus_enable || ia.mem_write_enable) && (ia.cpu_ready || ia.dma_ready)) overlap++;
      if (c == 2) begin
        checks++;
        if ({ia.mem_write_mask, ia.mem_write, ia.mem_address} !== {4'b1110, 32'h000000AA, 16'h8000}) begin
          errors++; $display("FAIL wr_fields got m=%b d=%h a=%h want 1110 000000aa 8000",
                              ia.mem_write_mask, ia.mem_write, ia.mem_address);
        end
      end
      if (ia.cpu_ready && rdy_cyc == 0) begin rdy_cyc = c; ia.cpu_req = 0; ia.cpu_write = 0; end
    end
    checks++;
    if (both !== 1) begin errors++; $display("FAIL wr_enable_cycles got %0d want 1", both); end
    checks++;
    if (rdy_cyc !== 3) begin errors++; $display("FAIL wr_ready_cycle got %0d want 3", rdy_cyc); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL wr_enable_ready_overlap got %0d want 0", overlap); end
    checks++;
    if (ia.cpu_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data_kept got %h want deadbeef", ia.cpu_data_out); end
  endtask

  task automatic test_round_robin();
    int rc[8];
    int rp[8];
    int n = 0;
    for (int k = 0; k < 8; k++) begin rc[k] = 0; rp[k] = 9; end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    ia.cpu_req = 1; ia.cpu_write = 0; ia.cpu_address = 16'h0100;
    ia.dma_req = 1; ia.dma_write = 0; ia.dma_address = 16'h0200; ia.mem_read = 32'hCAFE0001;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ia.cpu_ready || ia.dma_ready) begin
        if (n < 8) begin rc[n] = c; rp[n] = ia.dma_ready ? 1 : 0; end
        n++;
      end
    end
    ia.cpu_req = 0; ia.dma_req = 0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rr_pulse_count got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rc[k] !== 3 + 4 * k || rp[k] !== k % 2) begin
        errors++; $display("FAIL rr_pulse%0d got cycle %0d port %0d want cycle %0d port %0d", k, rc[k], rp[k], 3 + 4 * k, k % 2);
      end
    end
    checks++;
    if ({ia.cpu_data_out, ia.dma_data_out} !== {32'hCAFE0001, 32'hCAFE0001}) begin
      errors++; $display("FAIL rr_data got %h %h want cafe0001 cafe0001", ia.cpu_data_out, ia.dma_data_out);
    end
  endtask

  task automatic test_cpu_priority();
    int cpu_n = 0;
    int dma_n = 0;
    int g_hi = 0;
    ib.cpu_req = 1; ib.cpu_address = 16'h0300; ib.dma_req = 1; ib.dma_address = 16'h0400; ib.mem_read = 32'h0BADF00D;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ib.cpu_ready) cpu_n++;
      if (ib.dma_ready) dma_n++;
      if (grant_b) g_hi++;
    end
    ib.cpu_req = 0; ib.dma_req = 0;
    checks++;
    if (cpu_n !== 4) begin errors++; $display("FAIL prio_cpu_pulses got %0d want 4", cpu_n); end
    checks++;
    if (dma_n !== 0 || g_hi !== 0) begin errors++; $display("FAIL prio_dma got pulses %0d grant-cycles %0d want 0 0", dma_n, g_hi); end
  endtask

  task automatic test_latency3();
    @(negedge clk);
    ic.dma_req = 1; ic.dma_write = 0; ic.dma_address = 16'h1234; ic.mem_read = 32'hBAD0BAD0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({ic.mem_bus_enable, grant_c, ic.mem_address} !== {2'b11, 16'h1234}) begin
          errors++; $display("FAIL l3_issue got be=%b g=%b a=%h want 1 1 1234", ic.mem_bus_enable, grant_c, ic.mem_address);
        end
      end
      if (c == 4) begin
        checks++;
        if ({ic.dma_ready, busy_c, ic.mem_bus_enable} !== 3'b010) begin
          errors++; $display("FAIL l3_wait got rdy=%b busy=%b be=%b want 0 1 0", ic.dma_ready, busy_c, ic.mem_bus_enable);
        end
        ic.mem_read = 32'h11112222;
      end
      if (c == 5) begin
        checks++;
        if ({ic.dma_ready, ic.cpu_ready, ic.dma_data_out} !== {2'b10, 32'h11112222}) begin
          errors++; $display("FAIL l3_done got rdy=%b cpu_rdy=%b d=%h want 1 0 11112222", ic.dma_ready, ic.cpu_ready, ic.dma_data_out);
        end
        ic.mem_read = 32'h33334444; ic.dma_req = 0;
      end
    end
    checks++;
    if ({busy_c, ic.dma_data_out} !== {1'b0, 32'h11112222}) begin
      errors++; $display("FAIL l3_hold got busy=%b d=%h want 0 11112222", busy_c, ic.dma_data_out);
    end
  endtask

  task automatic test_reset_midflight();
    int rdy_seen = 0;
    int rdy_cyc = 0;
    @(negedge clk);
    ia.cpu_req = 1; ia.cpu_write = 0; ia.cpu_address = 16'h2468; ia.mem_read = 32'h55555555;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy_a, grant_a, ia.cpu_ready, ia.mem_bus_enable, ia.mem_address, ia.cpu_data_out} !== 52'd0) begin
      errors++; $display("FAIL rst_mid got busy=%b g=%b rdy=%b be=%b a=%h d=%h want all 0",
                          busy_a, grant_a, ia.cpu_ready, ia.mem_bus_enable, ia.mem_address, ia.cpu_data_out);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ia.cpu_ready || ia.dma_ready) rdy_seen++;
    end
    checks++;
    if (rdy_seen !== 0) begin errors++; $display("FAIL rst_mid_ready got %0d pulses want 0", rdy_seen); end
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({ia.mem_bus_enable, ia.mem_address} !== {1'b1, 16'h2468}) begin
          errors++; $display("FAIL rst_restart got be=%b a=%h want 1 2468", ia.mem_bus_enable, ia.mem_address);
        end
      end
      if (ia.cpu_ready && rdy_cyc == 0) begin rdy_cyc = c; ia.cpu_req = 0; end
    end
    checks++;
    if (rdy_cyc !== 3 || ia.cpu_data_out !== 32'h55555555) begin
      errors++; $display("FAIL rst_restart_done got cycle %0d d=%h want 3 55555555", rdy_cyc, ia.cpu_data_out);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_round_robin();
    test_cpu_priority();
    test_latency3();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end
endmodule
